// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase sequencer and its helpers.
package phase_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP_INSTR,
        STEP_PHASE,
        HALTED
    } state_t;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_ISTEP = 2'b01;
    localparam logic [1:0] MODE_PSTEP = 2'b10;

    // Active state entered from IDLE/HALTED on a press; mode 11 behaves as instruction step
    function automatic state_t start_state(input logic by_exec, input logic [1:0] mode);
        state_t next;
        case (mode)
            MODE_RUN:   next = by_exec ? RUN : STEP_INSTR;
            MODE_ISTEP: next = STEP_INSTR;
            MODE_PSTEP: next = STEP_PHASE;
            default:    next = STEP_INSTR;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/phase_sequencer_button_sync.sv
// Two-flop synchroniser for an active-low front-panel button, followed by a
// falling-edge detector that yields exactly one press pulse per press.
module button_sync (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);

    logic sync_a;
    logic sync_b;
    logic prev;

    // Synchronise the raw button and remember its previous synchronised level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

    assign press = prev & ~sync_b;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: owns the phase counter, drives one-hot phase
// enables and supports continuous run, instruction step, phase step and halt.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 5,
    parameter int PHASE_W    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec,
    input  logic                  step,
    input  logic [1:0]            mode,
    input  logic                  halt,
    output logic                  register_reset,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  running,
    output logic                  halted,
    output logic                  instr_done,
    output logic [CNT_W-1:0]      instr_count
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_t             state;
    logic [PHASE_W-1:0] step_cnt;
    logic [PHASE_W-1:0] next_phase;
    logic               pending_stop;
    logic               halt_pending;
    logic               exec_press;
    logic               step_press;
    logic               active;
    logic               at_last;
    logic               halt_now;

    button_sync u_exec_sync (
        .clock  (clock),
        .reset  (reset),
        .button (exec),
        .press  (exec_press)
    );

    button_sync u_step_sync (
        .clock  (clock),
        .reset  (reset),
        .button (step),
        .press  (step_press)
    );

    assign register_reset = reset;
    assign active         = (state == RUN) || (state == STEP_INSTR) || (state == STEP_PHASE);
    assign at_last        = active && (phase == LAST_PHASE);
    assign halt_now       = halt_pending || halt;
    assign next_phase     = (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
    assign running        = active;
    assign halted         = (state == HALTED);
    assign instr_done     = at_last;

    // Decode the registered phase into a one-hot enable while sequencing
    always_comb begin
        phase_en = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (active && (phase == PHASE_W'(i))) begin
                phase_en[i] = 1'b1;
            end
        end
    end

    // Main controller: state, phase counter, stop/halt requests and retire count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            phase        <= '0;
            step_cnt     <= '0;
            pending_stop <= 1'b0;
            halt_pending <= 1'b0;
            instr_count  <= '0;
        end else begin
            if (active && halt) begin
                halt_pending <= 1'b1;
            end
            if (at_last) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (exec_press || step_press) begin
                        state    <= start_state(exec_press, mode);
                        step_cnt <= '0;
                    end
                end
                RUN: begin
                    if (at_last && halt_now) begin
                        state        <= HALTED;
                        phase        <= '0;
                        pending_stop <= 1'b0;
                    end else if (at_last && pending_stop) begin
                        state        <= IDLE;
                        phase        <= '0;
                        pending_stop <= 1'b0;
                    end else begin
                        phase <= next_phase;
                        if (exec_press) begin
                            pending_stop <= 1'b1;
                        end
                    end
                end
                STEP_INSTR: begin
                    if (at_last && halt_now) begin
                        state <= HALTED;
                        phase <= '0;
                    end else if (step_cnt == LAST_PHASE) begin
                        state <= IDLE;
                        phase <= '0;
                    end else begin
                        phase    <= next_phase;
                        step_cnt <= step_cnt + PHASE_W'(1);
                    end
                end
                STEP_PHASE: begin
                    if (at_last && halt_now) begin
                        state <= HALTED;
                        phase <= '0;
                    end else begin
                        state <= IDLE;
                        phase <= next_phase;
                    end
                end
                HALTED: begin
                    if (exec_press || step_press) begin
                        state        <= start_state(exec_press, mode);
                        phase        <= '0;
                        step_cnt     <= '0;
                        halt_pending <= 1'b0;
                        pending_stop <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the processor's phase/run controller.
- Owns the instruction phase counter internally and sequences NUM_PHASES phase enables.
- Supports continuous run, single-instruction step and single-phase step, with a halt request that stops only at an instruction boundary.
- Sits between the front-panel buttons/halt decoder and the datapath; emits decoded, register-driven phase enables (no clock gating) plus status and a retired-instruction counter.

Parameters:
- NUM_PHASES, 5, phases per instruction (2..8).
- PHASE_W, 3, width of phase output, must satisfy 2**PHASE_W >= NUM_PHASES.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- exec  in  1  active-low start/stop button, asynchronous to clock.
- step  in  1  active-low step button, asynchronous to clock.
- mode  in  2  00 continuous, 01 instruction-step, 10 phase-step, 11 treated as 01.
- halt  in  1  active-high halt request from decode, synchronous.
- register_reset  out  1  equals reset, combinational passthrough.
- phase  out  PHASE_W  current phase index.
- phase_en  out  NUM_PHASES  one-hot enable for the current phase while active, else all 0.
- running  out  1  high in RUN or STEP.
- halted  out  1  high in HALTED.
- instr_done  out  1  one-cycle pulse in the cycle phase_en[NUM_PHASES-1] is high.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2**CNT_W.

Behaviour:
- Reset asserted (async): state=IDLE, phase=0, all outputs 0, pending_stop=0, count=0, and button synchronisers load 1 (released). Reset mid-instruction drops phase_en immediately.
- Buttons: each passes a 2-flop synchroniser, then a registered falling-edge detect producing a 1-cycle press pulse. Button sampled low at edges k, k+1, k+2 gives a state change on edge k+2. One pulse per press; holding the button produces no repeats.
- States: IDLE, RUN, STEP, HALTED.
- phase_en[i] = (state is RUN or STEP) and (phase == i), decoded from registers.
- IDLE:
  - exec press: mode 00 -> RUN; mode 01/11 -> STEP(instr); mode 10 -> STEP(phase).
  - step press: mode 10 -> STEP(phase); otherwise -> STEP(instr).
  - Both presses in the same cycle: exec wins.
- RUN:
  - phase advances +1 per cycle and wraps from NUM_PHASES-1 to 0.
  - An exec press sets pending_stop. Further presses while pending_stop is set are ignored.
  - At the last phase with pending_stop set: -> IDLE, phase=0, pending_stop cleared.
- STEP(instr): runs NUM_PHASES cycles starting at the current phase, then -> IDLE with phase=0. Presses during STEP are ignored.
- STEP(phase): active exactly one cycle, then phase increments (wrapping) and state -> IDLE. The phase is preserved across presses, so NUM_PHASES presses retire one instruction.
- Halt:
  - halt sampled high in any active cycle sets halt_pending.
  - At the last phase with halt_pending set: -> HALTED, phase=0. Halt has priority over pending_stop.
  - In HALTED, an exec press clears halt_pending and restarts per mode from phase 0. A step press restarts per the IDLE step rule from phase 0.
  - If halt stays high after restart, the block halts again at the next boundary.
- instr_done and the count increment happen in every active cycle where phase == NUM_PHASES-1, including the last phase-step press.

Decomposition:
- Package phase_seq_pkg holds:
  - state enum (IDLE, RUN, STEP_INSTR, STEP_PHASE, HALTED);
  - mode constants MODE_RUN=2'b00, MODE_ISTEP=2'b01, MODE_PSTEP=2'b10.
- Sub-module button_sync (2FF synchroniser plus falling-edge pulse, async active-low reset, reset value 1), instantiated for exec and step.

Test Plan:
- Reset then exec press with mode=00 -> phase_en sequence 00001, 00010, 00100, 01000, 10000 repeating; instr_done every 5th cycle; count=3 after 15 active cycles.
- Exec press mid-instruction at phase 2 in RUN -> phases 3 and 4 complete, then IDLE, phase=0, running=0, count incremented by one.
- mode=10 and five step presses -> one phase_en pulse per press (bits 0..4); instr_done only on the 5th press; count=1.
- RUN with halt pulsed at phase 1 -> completes phase 4, halted=1, phase_en=0; exec press -> RUN restarts at phase 0, halted=0.
- reset asserted during phase 3 of STEP -> phase_en=0 and count=0 in the same cycle without waiting for a clock edge; after release the block sits in IDLE until a press.
- exec and step pressed on the same edge in IDLE with mode=01 -> STEP(instr) via exec; a held exec button yields a single pulse; NUM_PHASES=3 build wraps phase 2 -> 0.
